// File: rtl/riscv_lsu_ram.sv
// riscv_lsu_ram: unified byte-addressed RAM with fetch port and RV32 load/store port, pipelined reads
module riscv_lsu_ram #(
  parameter int WORD_LENGTH = 32,
  parameter int NUM_MEM = 4096,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   imem_req,
  input  logic [WORD_LENGTH-1:0] imem_addr,
  output logic                   imem_valid,
  output logic [WORD_LENGTH-1:0] imem_rdata,
  output logic                   imem_fault,
  input  logic                   dmem_req,
  input  logic                   dmem_we,
  input  logic [1:0]             dmem_size,
  input  logic                   dmem_unsigned,
  input  logic [WORD_LENGTH-1:0] dmem_addr,
  input  logic [WORD_LENGTH-1:0] dmem_wdata,
  output logic                   dmem_valid,
  output logic [WORD_LENGTH-1:0] dmem_rdata,
  output logic                   dmem_fault
);
  localparam int AW = $clog2(NUM_MEM);
  logic [7:0] mem [NUM_MEM];
  logic [AW-1:0] da, ia;
  logic [1:0] dn;
  logic [WORD_LENGTH:0] dlast, ilast;
  logic d_fault, i_fault;
  logic [7:0] db [4];
  logic [7:0] ib [4];
  logic [WORD_LENGTH-1:0] d_load, i_word;
  logic [READ_LATENCY-1:0] dv, df, iv, ifl;
  logic [WORD_LENGTH-1:0] dd [READ_LATENCY];
  logic [WORD_LENGTH-1:0] id [READ_LATENCY];
  assign da = dmem_addr[AW-1:0];
  assign ia = imem_addr[AW-1:0];
  // Fault detection, array read and load extension for the current requests
  always_comb begin
    dn = dmem_size == 2'b00 ? 2'd0 : dmem_size == 2'b01 ? 2'd1 : 2'd3;
    dlast = {1'b0, dmem_addr} + (WORD_LENGTH+1)'(dn);
    ilast = {1'b0, imem_addr} + (WORD_LENGTH+1)'(3);
    d_fault = (dmem_size == 2'b11) | (dmem_size == 2'b01 & dmem_addr[0]) |
              (dmem_size == 2'b10 & |dmem_addr[1:0]) | (dlast >= (WORD_LENGTH+1)'(NUM_MEM));
    i_fault = |imem_addr[1:0] | (ilast >= (WORD_LENGTH+1)'(NUM_MEM));
    for (int k = 0; k < 4; k++) begin
      db[k] = mem[da + AW'(k)];
      ib[k] = mem[ia + AW'(k)];
    end
    i_word = {ib[3], ib[2], ib[1], ib[0]};
    d_load = dmem_size == 2'b00 ? {{24{~dmem_unsigned & db[0][7]}}, db[0]} :
             dmem_size == 2'b01 ? {{16{~dmem_unsigned & db[1][7]}}, db[1], db[0]} :
             {db[3], db[2], db[1], db[0]};
  end
  // Byte-lane store at the request edge; faults and reset suppress the write
  always_ff @(posedge clk)
    if (!rst && dmem_req && dmem_we && !d_fault)
      for (int k = 0; k < 4; k++)
        if (k <= int'(dn)) mem[da + AW'(k)] <= dmem_wdata[8*k +: 8];
  // Response pipeline: stage 0 samples the array, later stages delay; reset flushes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      dv <= '0;
      df <= '0;
      iv <= '0;
      ifl <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        dd[k] <= '0;
        id[k] <= '0;
      end
    end else begin
      dv[0] <= dmem_req;
      df[0] <= dmem_req & d_fault;
      dd[0] <= (dmem_req & ~dmem_we & ~d_fault) ? d_load : '0;
      iv[0] <= imem_req;
      ifl[0] <= imem_req & i_fault;
      id[0] <= (imem_req & ~i_fault) ? i_word : '0;
      for (int k = 1; k < READ_LATENCY; k++) begin
        dv[k] <= dv[k-1];
        df[k] <= df[k-1];
        dd[k] <= dd[k-1];
        iv[k] <= iv[k-1];
        ifl[k] <= ifl[k-1];
        id[k] <= id[k-1];
      end
    end
  end
  assign dmem_valid = dv[READ_LATENCY-1];
  assign dmem_fault = df[READ_LATENCY-1];
  assign dmem_rdata = dd[READ_LATENCY-1];
  assign imem_valid = iv[READ_LATENCY-1];
  assign imem_fault = ifl[READ_LATENCY-1];
  assign imem_rdata = id[READ_LATENCY-1];
endmodule

// File: tb/tb_riscv_lsu_ram.sv
// tb_riscv_lsu_ram: checks latency-1 and latency-3 instances against a byte-array reference model
module tb_riscv_lsu_ram;
  localparam int NUM = 4096;
  localparam int HMAX = 4096;
  logic clk = 0;
  logic rst, ireq, dreq, dwe, duns;
  logic [1:0] dsize;
  logic [31:0] iaddr, daddr, dwdata;
  logic o1_iv, o1_if, o1_dv, o1_df, o3_iv, o3_if, o3_dv, o3_df;
  logic [31:0] o1_ir, o1_dr, o3_ir, o3_dr;
  logic [7:0] mm [NUM];
  logic [33:0] hd [HMAX];
  logic [33:0] hi [HMAX];
  logic rh [HMAX];
  int cyc = 0, tests = 0, fails = 0;

  typedef struct {
    logic we; logic [1:0] sz; logic un; logic [31:0] a, w, ex; logic exf;
    logic ir; logic [31:0] ia, iex; logic iexf;
  } vec_t;
  vec_t tq [$];

  always #5 clk = ~clk;

  riscv_lsu_ram #(.READ_LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .imem_req(ireq), .imem_addr(iaddr), .imem_valid(o1_iv),
    .imem_rdata(o1_ir), .imem_fault(o1_if), .dmem_req(dreq), .dmem_we(dwe),
    .dmem_size(dsize), .dmem_unsigned(duns), .dmem_addr(daddr), .dmem_wdata(dwdata),
    .dmem_valid(o1_dv), .dmem_rdata(o1_dr), .dmem_fault(o1_df));
  riscv_lsu_ram #(.READ_LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .imem_req(ireq), .imem_addr(iaddr), .imem_valid(o3_iv),
    .imem_rdata(o3_ir), .imem_fault(o3_if), .dmem_req(dreq), .dmem_we(dwe),
    .dmem_size(dsize), .dmem_unsigned(duns), .dmem_addr(daddr), .dmem_wdata(dwdata),
    .dmem_valid(o3_dv), .dmem_rdata(o3_dr), .dmem_fault(o3_df));

  function automatic logic [31:0] pat(input int a);
    return 32'h13579BDF ^ (32'(a) * 32'h01000193);
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
  endfunction

  function automatic bit dfault_m(input logic [1:0] s, input logic [31:0] a);
    longint la = longint'({32'b0, a});
    int n = nbytes(s);
    return s == 2'd3 || la % n != 0 || la + n - 1 >= NUM;
  endfunction

  function automatic logic [33:0] dmodel();
    int n = nbytes(dsize);
    logic [31:0] v = 0;
    if (!dreq) return '0;
    if (dfault_m(dsize, daddr)) return {2'b11, 32'b0};
    if (dwe) return {2'b10, 32'b0};
    for (int k = 0; k < n; k++) v |= 32'(mm[daddr + k]) << (8 * k);
    if (!duns && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
    return {2'b10, v};
  endfunction

  function automatic logic [33:0] imodel();
    logic [31:0] v = 0;
    longint la = longint'({32'b0, iaddr});
    if (!ireq) return '0;
    if (la % 4 != 0 || la + 3 >= NUM) return {2'b11, 32'b0};
    for (int k = 0; k < 4; k++) v |= 32'(mm[iaddr + k]) << (8 * k);
    return {2'b10, v};
  endfunction

  function automatic logic [33:0] expect_at(input bit port_i, input int lat);
    int r = cyc - lat;
    if (r < 0) return '0;
    for (int k = r; k < cyc; k++) if (rh[k]) return '0;
    return port_i ? hi[r] : hd[r];
  endfunction

  task automatic chk(input string nm, input logic [33:0] got, input logic [33:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got v=%b f=%b d=%h want v=%b f=%b d=%h",
               nm, cyc, got[33], got[32], got[31:0], exp[33], exp[32], exp[31:0]);
    end
  endtask

  task automatic step();
    int n = nbytes(dsize);
    if (cyc >= HMAX - 1) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, HMAX - 1);
      $fatal(1);
    end
    hd[cyc] = rst ? '0 : dmodel();
    hi[cyc] = rst ? '0 : imodel();
    rh[cyc] = rst;
    if (!rst && dreq && dwe && !dfault_m(dsize, daddr))
      for (int k = 0; k < n; k++) mm[daddr + k] = 8'(dwdata >> (8 * k));
    @(posedge clk);
    #1;
    cyc++;
    chk("model_d_lat1", {o1_dv, o1_df, o1_dr}, expect_at(0, 1));
    chk("model_i_lat1", {o1_iv, o1_if, o1_ir}, expect_at(1, 1));
    chk("model_d_lat3", {o3_dv, o3_df, o3_dr}, expect_at(0, 3));
    chk("model_i_lat3", {o3_iv, o3_if, o3_ir}, expect_at(1, 3));
  endtask

  task automatic drv_d(input logic we, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] w);
    dreq = 1; dwe = we; dsize = sz; duns = un; daddr = a; dwdata = w;
  endtask

  task automatic idle();
    dreq = 0; dwe = 0; ireq = 0;
  endtask

  function automatic logic [31:0] raddr();
    case ($urandom_range(0, 7))
      0, 1, 2, 3: return 32'($urandom_range(0, 255));
      4, 5: return 32'h0F00 + 32'($urandom_range(0, 255));
      6: return 32'h0FF8 + 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  function automatic vec_t mkv(input logic we, input logic [1:0] sz, input logic un,
                               input logic [31:0] a, input logic [31:0] w, input logic [31:0] ex,
                               input logic exf, input logic ir, input logic [31:0] ia,
                               input logic [31:0] iex, input logic iexf);
    vec_t v;
    v.we = we; v.sz = sz; v.un = un; v.a = a; v.w = w; v.ex = ex; v.exf = exf;
    v.ir = ir; v.ia = ia; v.iex = iex; v.iexf = iexf;
    return v;
  endfunction

  initial begin
    logic [31:0] p;
    p = pat(32'h0FFC);
    tq.push_back(mkv(1, 2, 0, 32'h10, 32'h8899AABB, 32'h0, 0, 0, 0, 0, 0));
    tq.push_back(mkv(0, 2, 0, 32'h10, 0, 32'h8899AABB, 0, 0, 0, 0, 0));
    tq.push_back(mkv(1, 0, 0, 32'h11, 32'h000000F0, 32'h0, 0, 1, 32'h10, 32'h8899AABB, 0));
    tq.push_back(mkv(0, 0, 0, 32'h11, 0, 32'hFFFFFFF0, 0, 0, 0, 0, 0));
    tq.push_back(mkv(0, 0, 1, 32'h11, 0, 32'h000000F0, 0, 0, 0, 0, 0));
    tq.push_back(mkv(0, 1, 0, 32'h12, 0, 32'hFFFF8899, 0, 0, 0, 0, 0));
    tq.push_back(mkv(0, 1, 1, 32'h12, 0, 32'h00008899, 0, 0, 0, 0, 0));
    tq.push_back(mkv(0, 2, 0, 32'h10, 0, 32'h8899F0BB, 0, 0, 0, 0, 0));
    tq.push_back(mkv(0, 1, 0, 32'h13, 0, 32'h0, 1, 0, 0, 0, 0));
    tq.push_back(mkv(1, 2, 0, 32'h0FFE, 32'h55667788, 32'h0, 1, 1, 32'h02, 32'h0, 1));
    tq.push_back(mkv(0, 2, 0, 32'h0FFC, 0, p, 0, 1, 32'h0FFC, p, 0));
    tq.push_back(mkv(0, 3, 0, 32'h20, 0, 32'h0, 1, 1, 32'h1000, 32'h0, 1));
    tq.push_back(mkv(0, 0, 0, 32'h0FFF, 0, {{24{p[31]}}, p[31:24]}, 0, 0, 0, 0, 0));
    tq.push_back(mkv(0, 2, 0, 32'h1000, 0, 32'h0, 1, 0, 0, 0, 0));
    tq.push_back(mkv(1, 1, 0, 32'h12, 32'hABCD1234, 32'h0, 0, 0, 0, 0, 0));
    tq.push_back(mkv(0, 2, 0, 32'h10, 0, 32'h1234F0BB, 0, 1, 32'h10, 32'h1234F0BB, 0));
    tq.push_back(mkv(0, 1, 1, 32'h0FFE, 0, {16'h0, p[31:16]}, 0, 0, 0, 0, 0));
    for (int i = 0; i < NUM; i++) mm[i] = 8'h00;
    rst = 1; iaddr = 0; dsize = 0; duns = 0; daddr = 0; dwdata = 0;
    idle();
    step();
    chk("reset_d_lat1", {o1_dv, o1_df, o1_dr}, 34'h0);
    chk("reset_i_lat3", {o3_iv, o3_if, o3_ir}, 34'h0);
    step();
    rst = 0;
    for (int a = 0; a < 256; a += 4) begin drv_d(1, 2, 0, 32'(a), pat(a)); step(); end
    for (int a = 32'h0F00; a < NUM; a += 4) begin drv_d(1, 2, 0, 32'(a), pat(a)); step(); end
    idle();
    step();
    foreach (tq[i]) begin
      drv_d(tq[i].we, tq[i].sz, tq[i].un, tq[i].a, tq[i].w);
      ireq = tq[i].ir; iaddr = tq[i].ia;
      step();
      chk($sformatf("tbl%0d_d1", i), {o1_dv, o1_df, o1_dr}, {1'b1, tq[i].exf, tq[i].ex});
      if (tq[i].ir) chk($sformatf("tbl%0d_i1", i), {o1_iv, o1_if, o1_ir}, {1'b1, tq[i].iexf, tq[i].iex});
      idle();
      step();
      step();
      chk($sformatf("tbl%0d_d3", i), {o3_dv, o3_df, o3_dr}, {1'b1, tq[i].exf, tq[i].ex});
      if (tq[i].ir) chk($sformatf("tbl%0d_i3", i), {o3_iv, o3_if, o3_ir}, {1'b1, tq[i].iexf, tq[i].iex});
    end
    drv_d(0, 2, 0, 32'h0, 0); step();
    drv_d(0, 2, 0, 32'h4, 0); step();
    drv_d(0, 2, 0, 32'h8, 0); step();
    chk("b2b_0", {o3_dv, o3_df, o3_dr}, {2'b10, pat(0)});
    idle(); step();
    chk("b2b_4", {o3_dv, o3_df, o3_dr}, {2'b10, pat(4)});
    step();
    chk("b2b_8", {o3_dv, o3_df, o3_dr}, {2'b10, pat(8)});
    drv_d(1, 2, 0, 32'h40, 32'hCAFEF00D); ireq = 1; iaddr = 32'h40; step();
    chk("rbw_i1", {o1_iv, o1_if, o1_ir}, {2'b10, pat(32'h40)});
    dreq = 0; step();
    chk("raw_i1", {o1_iv, o1_if, o1_ir}, {2'b10, 32'hCAFEF00D});
    idle(); step();
    chk("rbw_i3", {o3_iv, o3_if, o3_ir}, {2'b10, pat(32'h40)});
    step();
    chk("raw_i3", {o3_iv, o3_if, o3_ir}, {2'b10, 32'hCAFEF00D});
    drv_d(0, 2, 0, 32'h4, 0); step();
    rst = 1; drv_d(1, 2, 0, 32'h4, 32'h11111111); step();
    rst = 0; idle();
    for (int i = 0; i < 5; i++) begin step(); chk("rst_drop_d3", {o3_dv, o3_df, o3_dr}, 34'h0); end
    drv_d(0, 2, 0, 32'h4, 0); step();
    chk("rst_nowrite_d1", {o1_dv, o1_df, o1_dr}, {2'b10, pat(4)});
    drv_d(1, 2, 0, 32'h20, 32'hDEADBEEF); step();
    rst = 1; idle(); ireq = 1; iaddr = 32'h20;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("in_rst_d1", {o1_dv, o1_df, o1_dr}, 34'h0);
      chk("in_rst_i1", {o1_iv, o1_if, o1_ir}, 34'h0);
      chk("in_rst_d3", {o3_dv, o3_df, o3_dr}, 34'h0);
      chk("in_rst_i3", {o3_iv, o3_if, o3_ir}, 34'h0);
    end
    rst = 0; idle(); drv_d(0, 2, 0, 32'h20, 0); step();
    chk("persist_d1", {o1_dv, o1_df, o1_dr}, {2'b10, 32'hDEADBEEF});
    idle(); step(); step();
    chk("persist_d3", {o3_dv, o3_df, o3_dr}, {2'b10, 32'hDEADBEEF});
    for (int i = 0; i < 500; i++) begin
      rst = $urandom_range(0, 49) == 0;
      dreq = $urandom_range(0, 3) != 0;
      dwe = $urandom_range(0, 2) == 0;
      dsize = 2'($urandom_range(0, 3));
      duns = 1'($urandom_range(0, 1));
      daddr = raddr();
      dwdata = $urandom;
      ireq = 1'($urandom_range(0, 1));
      iaddr = $urandom_range(0, 3) != 0 ? (raddr() & ~32'h3) : raddr();
      step();
    end
    rst = 0; idle();
    for (int i = 0; i < 4; i++) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
